interval_timer_ctrl: RTL and testbench

Sequencing controller for a free-running up-counter: turns a plain incrementing register into a programmable interval timer with start/stop/pause control and one-shot or auto-reload modes. It owns the counter datapath and its enable/clear, and gives downstream logic a single-cycle `expire` strobe every programmed interval. It is intended as the standard timebase generator for blocks that need periodic ticks or timeouts.

---
 rtl/interval_timer_pkg.sv | 13 +
 rtl/interval_timer_ctrl_if.sv | 25 ++
 rtl/timer_count_dp.sv | 29 ++
 rtl/interval_timer_ctrl.sv | 105 ++++++++++
 tb/tb_interval_timer_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interval_timer_pkg.sv
// Shared types and defaults for the interval timer controller.
// Provides the FSM state enum and the default count width.
package interval_timer_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_e;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Command/status bundle for the interval timer.
// master drives start/stop/pause/period/auto_reload; slave returns status.
interface interval_timer_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] period;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             paused;
    logic             expire;

    modport master (
        output start, stop, pause, period, auto_reload,
        input  count, running, paused, expire
    );

    modport slave (
        input  start, stop, pause, period, auto_reload,
        output count, running, paused, expire
    );
endinterface

// File: rtl/timer_count_dp.sv
// Counter datapath: WIDTH-bit register with sync clear and enable.
// Ports: clk, rst, clr, en, limit in; count, last (count == limit-1) out.
import interval_timer_pkg::*;

module timer_count_dp #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             last
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

    // limit is never 0 while counting, so limit-1 cannot underflow
    // in any state where last is consulted.
    assign last = (count == (limit - ONE));
endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: start/stop/pause, one-shot or reload.
// Ports: clk, rst (sync, active-high), bus (slave modport of the if).
import interval_timer_pkg::*;

module interval_timer_ctrl #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    interval_timer_ctrl_if.slave bus
);
    timer_state_e     state_q;
    timer_state_e     state_d;
    logic [WIDTH-1:0] period_q;
    logic             reload_q;
    logic             expire_q;
    logic             expire_d;
    logic             load;
    logic             clr;
    logic             en;
    logic             last;
    logic [WIDTH-1:0] cnt;

    timer_count_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .limit (period_q),
        .count (cnt),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            reload_q <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            expire_q <= expire_d;
            if (load) begin
                period_q <= bus.period;
                reload_q <= bus.auto_reload;
            end
        end
    end

    // Priority: stop > start > pause. A zero-period start restarting
    // an active timer degenerates to stop; in IDLE it is ignored.
    always_comb begin
        state_d  = state_q;
        expire_d = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        en       = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else if (bus.start && (bus.period != '0)) begin
            state_d = RUN;
            load    = 1'b1;
            clr     = 1'b1;
        end else if (bus.start && (state_q != IDLE)) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    clr = 1'b1;
                end
                // HOLD with pause low resumes counting in the same
                // cycle, so it shares the RUN advance path.
                RUN, HOLD: begin
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        if (last) begin
                            clr      = 1'b1;
                            expire_d = 1'b1;
                            if (!reload_q) begin
                                state_d = IDLE;
                            end
                        end else begin
                            en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    assign bus.count   = cnt;
    assign bus.running = (state_q != IDLE);
    assign bus.paused  = (state_q == HOLD);
    assign bus.expire  = expire_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl (WIDTH=4).
// Checks {count,running,paused,expire} after each clock edge.
module tb_interval_timer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] obs;
    logic [6:0] exp;

    interval_timer_ctrl_if #(.WIDTH(4)) bus ();

    interval_timer_ctrl #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.count, bus.running, bus.paused, bus.expire};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.pause       = 1'b0;
        bus.period      = 4'd0;
        bus.auto_reload = 1'b0;
    endtask

    task automatic go(input logic [3:0] n, input logic ar);
        bus.period      = n;
        bus.auto_reload = ar;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic halt();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_init got %h want %h", obs, exp);
        end
        go(4'd5, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", obs, exp);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_after got %h want %h", obs, exp);
        end
    endtask

    task automatic test_one_shot();
        go(4'd5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            exp = {k[3:0], 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL oneshot_cnt%0d got %h want %h", k, obs, exp);
            end
            step();
        end
        exp = {4'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL oneshot_exp got %h want %h", obs, exp);
        end
        step();
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL oneshot_done got %h want %h", obs, exp);
        end
    endtask

    task automatic test_auto_reload(input int n, input int cyc);
        go(n[3:0], 1'b1);
        for (int i = 0; i < cyc; i++) begin
            int m;
            m = i % n;
            exp = {m[3:0], 1'b1, 1'b0, (i > 0) && (m == 0)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL auto%0d_i%0d got %h want %h",
                         n, i, obs, exp);
            end
            step();
        end
        halt();
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL auto%0d_stop got %h want %h", n, obs, exp);
        end
    endtask

    task automatic test_pause();
        go(4'd4, 1'b1);
        step();
        step();
        exp = {4'd2, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL pause_pre got %h want %h", obs, exp);
        end
        bus.pause = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            exp = {4'd2, 1'b1, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pause_hold%0d got %h want %h", j, obs, exp);
            end
        end
        bus.pause = 1'b0;
        step();
        exp = {4'd3, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL pause_resume got %h want %h", obs, exp);
        end
        step();
        exp = {4'd0, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL pause_exp got %h want %h", obs, exp);
        end
        halt();
    endtask

    task automatic test_zero_period();
        go(4'd0, 1'b1);
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL zero_idle got %h want %h", obs, exp);
        end
        go(4'd5, 1'b1);
        step();
        go(4'd0, 1'b1);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL zero_restart got %h want %h", obs, exp);
        end
    endtask

    task automatic test_start_stop();
        bus.stop = 1'b1;
        go(4'd5, 1'b1);
        bus.stop = 1'b0;
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ss_idle got %h want %h", obs, exp);
        end
        go(4'd5, 1'b1);
        step();
        bus.stop = 1'b1;
        go(4'd7, 1'b1);
        bus.stop = 1'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ss_run got %h want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        go(4'd4, 1'b1);
        step();
        step();
        go(4'd6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            exp = {k[3:0], 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL restart_cnt%0d got %h want %h", k, obs, exp);
            end
            step();
        end
        exp = {4'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL restart_exp got %h want %h", obs, exp);
        end
        step();
    endtask

    task automatic test_stop_suppress();
        go(4'd4, 1'b1);
        step();
        step();
        step();
        exp = {4'd3, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL supp_pre got %h want %h", obs, exp);
        end
        halt();
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL supp_stop got %h want %h", obs, exp);
        end
        step();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL supp_after got %h want %h", obs, exp);
        end
    endtask

    task automatic test_start_pause();
        bus.pause = 1'b1;
        go(4'd3, 1'b1);
        exp = {4'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sp_start got %h want %h", obs, exp);
        end
        step();
        exp = {4'd0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sp_hold got %h want %h", obs, exp);
        end
        bus.pause = 1'b0;
        step();
        exp = {4'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sp_resume got %h want %h", obs, exp);
        end
        halt();
    endtask

    task automatic test_period_one();
        go(4'd1, 1'b1);
        exp = {4'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL n1_start got %h want %h", obs, exp);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {4'd0, 1'b1, 1'b0, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL n1_auto%0d got %h want %h", i, obs, exp);
            end
        end
        halt();
        go(4'd1, 1'b0);
        step();
        exp = {4'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL n1_oneshot got %h want %h", obs, exp);
        end
        step();
        exp = 7'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL n1_done got %h want %h", obs, exp);
        end
    endtask

    initial begin
        quiet();
        test_reset();
        test_one_shot();
        test_auto_reload(3, 10);
        test_auto_reload(15, 32);
        test_pause();
        test_zero_period();
        test_start_stop();
        test_back_to_back();
        test_stop_suppress();
        test_start_pause();
        test_period_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
